nmos_famux_arb: RTL and testbench

- Round-robin arbiter and sequencer for one shared 3-input NMOS_FAMUX bus node.
- Three requesters compete for the node. The block drives the mux select lines (sa/sb/sc) and the force line (ff).
- Every ownership change is preceded by a precharge phase with ff=1, which drives the node high through the selected leg.
- Burst length is bounded so that no requester can starve the others.

---
 rtl/nmos_arb_pkg.sv | 45 ++++
 rtl/nmos_rr_pick3.sv | 21 ++
 rtl/nmos_famux_arb.sv | 132 +++++++++++++
 tb/tb_nmos_famux_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nmos_arb_pkg.sv
// Shared types and helpers for arbiters that sequence a shared NMOS FAMUX node.
// Covers precharge, grant and round-robin owner selection.
package nmos_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRECH = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } pick_t;

    // Scan starts one past the previous owner, so the previous owner has lowest priority.
    function automatic pick_t rr_pick(input logic [2:0] req, input logic [1:0] last);
        pick_t      res;
        logic [1:0] cand;
        res.valid = 1'b0;
        res.idx   = OWNER_NONE;
        for (int k = 0; k < 3; k++) begin
            cand = 2'((int'(last) + 1 + k) % 3);
            if (req[cand] && !res.valid) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] leg_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/nmos_rr_pick3.sv
// Combinational 3-way round-robin picker for a shared NMOS node.
module nmos_rr_pick3
    import nmos_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] winner
);

    pick_t pick_s;

    // Winner search starting after the last owner
    always_comb begin
        pick_s = rr_pick(req, last);
    end

    assign valid  = pick_s.valid;
    assign winner = pick_s.idx;

endmodule

// File: rtl/nmos_famux_arb.sv
// Round-robin arbiter and sequencer for one 3-input NMOS FAMUX bus node.
// Every ownership change passes through a precharge phase (ff high).
module nmos_famux_arb
    import nmos_arb_pkg::*;
#(
    parameter int PRE_CYC   = 1,
    parameter int MAX_BURST = 4,
    parameter int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic       main_clk,
    input  logic       rst,
    input  logic [2:0] req,
    output logic       sa,
    output logic       sb,
    output logic       sc,
    output logic       ff,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy
);

    localparam logic [3:0]    PRE_LOAD   = (PRE_CYC == 0) ? 4'd0 : 4'(PRE_CYC - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    arb_state_t    state_r, nxt_state_s;
    logic [1:0]    win_r, nxt_win_s;
    logic [1:0]    last_r, nxt_last_s;
    logic [3:0]    pcnt_r, nxt_pcnt_s;
    logic [BW-1:0] bcnt_r, nxt_bcnt_s;
    logic          rearb_s;
    logic          pick_valid_s;
    logic [1:0]    pick_idx_s;
    logic [2:0]    nxt_sel_s;
    logic [2:0]    nxt_gnt_s;

    // last_r already equals the owner while in GRANT, so one picker serves every state
    nmos_rr_pick3 u_pick (
        .req    (req),
        .last   (last_r),
        .valid  (pick_valid_s),
        .winner (pick_idx_s)
    );

    // Next-state decision: sequencing counters plus re-arbitration on ownership release
    always_comb begin
        nxt_state_s = state_r;
        nxt_win_s   = win_r;
        nxt_last_s  = last_r;
        nxt_pcnt_s  = pcnt_r;
        nxt_bcnt_s  = bcnt_r;
        rearb_s     = 1'b0;
        case (state_r)
            IDLE: begin
                rearb_s = 1'b1;
            end
            PRECH: begin
                if (!req[win_r]) begin
                    rearb_s = 1'b1;
                end else if (pcnt_r == 4'd0) begin
                    nxt_state_s = GRANT;
                    nxt_bcnt_s  = BURST_ONE;
                    nxt_last_s  = win_r;
                end else begin
                    nxt_pcnt_s = pcnt_r - 4'd1;
                end
            end
            GRANT: begin
                if (!req[win_r] || (bcnt_r == BURST_LAST)) begin
                    rearb_s = 1'b1;
                end else begin
                    nxt_bcnt_s = bcnt_r + BURST_ONE;
                end
            end
            default: begin
                rearb_s = 1'b1;
            end
        endcase

        if (rearb_s) begin
            if (!pick_valid_s) begin
                nxt_state_s = IDLE;
            end else if (PRE_CYC == 0) begin
                nxt_state_s = GRANT;
                nxt_win_s   = pick_idx_s;
                nxt_last_s  = pick_idx_s;
                nxt_bcnt_s  = BURST_ONE;
            end else begin
                nxt_state_s = PRECH;
                nxt_win_s   = pick_idx_s;
                nxt_pcnt_s  = PRE_LOAD;
            end
        end else begin
            nxt_state_s = nxt_state_s;
        end

        nxt_sel_s = (nxt_state_s != IDLE)  ? leg_onehot(nxt_win_s) : 3'b000;
        nxt_gnt_s = (nxt_state_s == GRANT) ? nxt_sel_s : 3'b000;
    end

    // FSM state, counters and registered bus-control outputs
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            win_r   <= 2'd0;
            last_r  <= 2'd2;
            pcnt_r  <= 4'd0;
            bcnt_r  <= {BW{1'b0}};
            sa      <= 1'b0;
            sb      <= 1'b0;
            sc      <= 1'b0;
            ff      <= 1'b1;
            gnt     <= 3'b000;
            owner   <= OWNER_NONE;
            busy    <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            win_r   <= nxt_win_s;
            last_r  <= nxt_last_s;
            pcnt_r  <= nxt_pcnt_s;
            bcnt_r  <= nxt_bcnt_s;
            sa      <= nxt_sel_s[0];
            sb      <= nxt_sel_s[1];
            sc      <= nxt_sel_s[2];
            ff      <= (nxt_state_s != GRANT);
            gnt     <= nxt_gnt_s;
            owner   <= (nxt_state_s == IDLE) ? OWNER_NONE : nxt_win_s;
            busy    <= (nxt_state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_nmos_famux_arb.sv
// Bench for nmos_famux_arb: three configurations run in lockstep against an owner/phase model.
module tb_nmos_famux_arb;

    localparam logic [9:0] RST_OBS = 10'b0001000110;

    logic       main_clk;
    logic       rst_v [3];
    logic [2:0] req_v [3];
    logic [9:0] obs   [3];

    int n_checks = 0;
    int n_pass   = 0;

    int p_pre [3] = '{1, 1, 0};
    int p_max [3] = '{4, 2, 4};

    int m_owner [3];
    int m_pre   [3];
    int m_burst [3];
    int m_last  [3];

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PC = (g == 2) ? 0 : 1;
        localparam int MB = (g == 1) ? 2 : 4;
        logic       sa, sb, sc, ff, busy;
        logic [2:0] gnt;
        logic [1:0] owner;
        nmos_famux_arb #(.PRE_CYC(PC), .MAX_BURST(MB)) u_dut (
            .main_clk (main_clk),
            .rst      (rst_v[g]),
            .req      (req_v[g]),
            .sa       (sa),
            .sb       (sb),
            .sc       (sc),
            .ff       (ff),
            .gnt      (gnt),
            .owner    (owner),
            .busy     (busy)
        );
        assign obs[g] = {sa, sb, sc, ff, gnt, owner, busy};
    end

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: owner (-1 = none), precharge cycles still to show, burst cycles used.
    task automatic m_reset(input int i);
        m_owner[i] = -1; m_pre[i] = 0; m_burst[i] = 0; m_last[i] = 2;
    endtask

    task automatic m_start(input int i, input int w);
        m_owner[i] = w;
        m_pre[i]   = p_pre[i];
        if (m_pre[i] == 0) begin m_burst[i] = 1; m_last[i] = w; end
    endtask

    task automatic m_arb(input int i, input logic [2:0] r);
        int w = -1;
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last[i] + k) % 3;
            if (w < 0 && r[c[1:0]]) w = c;
        end
        if (w < 0) m_owner[i] = -1;
        else m_start(i, w);
    endtask

    task automatic m_step(input int i, input logic [2:0] r);
        logic [1:0] o;
        if (m_owner[i] < 0) begin
            m_arb(i, r);
        end else begin
            o = 2'(m_owner[i]);
            if (!r[o]) m_arb(i, r);
            else if (m_pre[i] > 0) begin
                m_pre[i]--;
                if (m_pre[i] == 0) begin m_burst[i] = 1; m_last[i] = m_owner[i]; end
            end else if (m_burst[i] >= p_max[i]) m_arb(i, r);
            else m_burst[i]++;
        end
    endtask

    function automatic logic [9:0] m_exp(input int i);
        logic [2:0] sel;
        logic       granted;
        logic [1:0] own;
        sel     = (m_owner[i] >= 0) ? (3'b001 << m_owner[i]) : 3'b000;
        granted = (m_owner[i] >= 0) && (m_pre[i] == 0);
        own     = (m_owner[i] >= 0) ? 2'(m_owner[i]) : 2'd3;
        return {sel[0], sel[1], sel[2], !granted, granted ? sel : 3'b000, own, m_owner[i] >= 0};
    endfunction

    function automatic logic inv_ok(input logic [9:0] o);
        logic [2:0] sel;
        sel = {o[7], o[8], o[9]};
        return ($countones(sel) <= 1)
            && ((o[5:3] == 3'b000) || !o[6])
            && ((o[5:3] & ~sel) == 3'b000)
            && ((o[2:1] == 2'd3) == (sel == 3'b000));
    endfunction

    task automatic tick();
        @(posedge main_clk);
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) m_reset(i);
            else m_step(i, req_v[i]);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("out%0d", i), obs[i], m_exp(i));
            check($sformatf("inv%0d", i), 10'(inv_ok(obs[i])), 10'd1);
        end
    endtask

    task automatic pulse_rst(input int i);
        rst_v[i] = 1'b1;
        #1;
        check($sformatf("arst%0d", i), obs[i], RST_OBS);
        m_reset(i);
        rst_v[i] = 1'b0;
        #1;
    endtask

    task automatic set_all(input logic [2:0] r);
        for (int i = 0; i < 3; i++) req_v[i] = r;
    endtask

    logic [2:0] tr_a [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd1};
    logic [2:0] tr_c [12] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
    int order_exp [4] = '{0, 1, 2, 0};
    int order_q [$];

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1;
            req_v[i] = 3'b000;
            m_reset(i);
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        repeat (10) begin
            tick();
            for (int i = 0; i < 3; i++) check("idle", obs[i], RST_OBS);
        end

        // Sole requester, full round-robin, and zero-precharge handover
        req_v[0] = 3'b001; req_v[1] = 3'b111; req_v[2] = 3'b011;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("gnt_a", 10'(obs[0][5:3]), 10'(tr_a[k]));
            check("gnt_c", 10'(obs[2][5:3]), 10'(tr_c[k]));
            check("ff_c", 10'(obs[2][6]), 10'd0);
            if (obs[1][5:3] != 3'b000) begin
                if (order_q.size() == 0 || order_q[$] != int'(obs[1][2:1]))
                    order_q.push_back(int'(obs[1][2:1]));
            end
        end
        check("order_n", 10'(order_q.size() >= 4), 10'd1);
        if (order_q.size() >= 4)
            for (int k = 0; k < 4; k++) check("order", 10'(order_q[k]), 10'(order_exp[k]));

        // Drop during precharge hands the leg to the other pending requester
        set_all(3'b000);
        repeat (3) tick();
        set_all(3'b010);
        tick();
        check("pre_own", 10'(obs[0][2:1]), 10'd1);
        set_all(3'b100);
        tick();
        check("drop_own", 10'(obs[0][2:1]), 10'd2);
        check("drop_gnt", 10'(obs[0][5:3]), 10'd0);
        check("drop_sc", 10'(obs[0][7]), 10'd1);
        tick();
        check("drop_g2", 10'(obs[0][5:3]), 10'd4);

        // Asynchronous reset in the middle of requester 1's grant
        set_all(3'b000);
        repeat (3) tick();
        set_all(3'b010);
        repeat (2) tick();
        check("g1_pre_rst", 10'(obs[0][5:3]), 10'd2);
        for (int i = 0; i < 3; i++) pulse_rst(i);
        set_all(3'b011);
        tick();
        for (int i = 0; i < 3; i++) check("rst_win0", 10'(obs[i][2:1]), 10'd0);

        // Randomized traffic with occasional asynchronous resets
        repeat (400) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 3) == 0) req_v[i] = 3'($urandom_range(0, 7));
            tick();
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 59) == 0) pulse_rst(i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
